// File: rtl/sd_cic_decimator.sv
// sd_cic_decimator: CIC decimator for the 3-bit sigma-delta bitstream.
// Maps each 3-bit word to x = 2*popcount - 3, integrates ORDER times at the
// input rate, decimates by DECIM, differentiates ORDER times at the output
// rate and presents full-precision words on a valid/ready interface.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                input register, integrators and decimation counter advance
//   bs_in[2:0]        modulator bitstream (1 => +1, 0 => -1)
//   clr_ovr           synchronous clear of the sticky overrun flag
//   out_data[OUT_W-1:0] signed decimated sample
//   out_valid/out_ready handshake for out_data
//   ovr               sticky flag: a finished sample was dropped
module sd_cic_decimator #(
  parameter int unsigned ORDER      = 3,
  parameter int unsigned DECIM      = 64,
  parameter int unsigned LOG2_DECIM = 6,
  parameter int unsigned OUT_W      = 3 + ORDER * LOG2_DECIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       bs_in,
  input  logic             clr_ovr,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovr
);

  localparam int unsigned WARM_N = ORDER + 1;
  localparam int unsigned WARM_W = $clog2(WARM_N + 1);

  logic [1:0]            w_pop;
  logic [OUT_W-1:0]      w_x;
  logic                  w_strobe;
  logic [OUT_W-1:0]      w_comb_out;
  logic [OUT_W-1:0]      w_dly_nxt [ORDER];
  logic                  w_ovr_set;

  logic [OUT_W-1:0]      r_x;
  logic [OUT_W-1:0]      r_int [ORDER];
  logic [LOG2_DECIM-1:0] r_dec_cnt;
  logic [OUT_W-1:0]      r_dly [ORDER];
  logic [OUT_W-1:0]      r_y;
  logic                  r_y_vld;
  logic [WARM_W-1:0]     r_warm_cnt;
  logic [OUT_W-1:0]      r_out_data;
  logic                  r_out_valid;
  logic                  r_ovr;

  // 2*popcount - 3 computed modulo 2^OUT_W is already the sign-extended value
  assign w_pop = 2'(bs_in[0]) + 2'(bs_in[1]) + 2'(bs_in[2]);
  assign w_x   = OUT_W'({w_pop, 1'b0}) - OUT_W'(3);

  assign w_strobe = en && (r_dec_cnt == LOG2_DECIM'(DECIM - 1));

  // Input register, integrator chain and decimation counter (all wrap freely)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_dec_cnt <= '0;
      for (int unsigned k = 0; k < ORDER; k++) r_int[k] <= '0;
    end else if (en) begin
      r_x       <= w_x;
      r_dec_cnt <= r_dec_cnt + LOG2_DECIM'(1);
      r_int[0]  <= r_int[0] + r_x;
      for (int unsigned k = 1; k < ORDER; k++) r_int[k] <= r_int[k] + r_int[k-1];
    end
  end

  // Comb chain: each stage subtracts its own input from the previous strobe
  always_comb begin
    logic [OUT_W-1:0] v_acc;
    v_acc = r_int[ORDER-1];
    for (int unsigned k = 0; k < ORDER; k++) begin
      w_dly_nxt[k] = v_acc;
      v_acc        = v_acc - r_dly[k];
    end
    w_comb_out = v_acc;
  end

  // Comb delays, result register and warm-up gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y        <= '0;
      r_y_vld    <= 1'b0;
      r_warm_cnt <= '0;
      for (int unsigned k = 0; k < ORDER; k++) r_dly[k] <= '0;
    end else begin
      r_y_vld <= w_strobe && (r_warm_cnt == WARM_W'(WARM_N));
      if (w_strobe) begin
        r_y <= w_comb_out;
        for (int unsigned k = 0; k < ORDER; k++) r_dly[k] <= w_dly_nxt[k];
        if (r_warm_cnt != WARM_W'(WARM_N)) r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      end
    end
  end

  assign w_ovr_set = r_y_vld && r_out_valid && !out_ready;

  // Output holding register; a new word replaces one being accepted this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (r_y_vld) begin
        if (!r_out_valid || out_ready) begin
          r_out_data  <= r_y;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Bench for sd_cic_decimator at default parameters. The reference computes each
// decimated word in closed form: after N active cycles the third integrator holds
// sum_k x(k)*C(N-1-k,2); the output is the third difference of that quantity
// sampled once per decimation period.
module tb_sd_cic_decimator;
  localparam int OUT_W = 21;
  localparam int DEC   = 64;
  localparam int WARM  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [2:0]       bs_in = 3'b111;
  logic             clr_ovr = 1'b0;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             ovr;

  sd_cic_decimator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bs_in    (bs_in),
    .clr_ovr  (clr_ovr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic cmp_en = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int xh [0:8191];
  int n_act = 0;
  int m_strobes = 0;
  logic m_pend = 1'b0;
  logic m_set = 1'b0;
  logic signed [OUT_W-1:0] m_pend_y = '0;
  logic signed [OUT_W-1:0] md = '0;
  logic mv = 1'b0;
  logic movr = 1'b0;

  function automatic longint i3_at(input int nn);
    longint s = 0;
    longint a;
    if (nn <= 2) return 0;
    for (int k = 1; k <= nn - 2; k++) begin
      a = longint'(nn - 1 - k);
      s += longint'(xh[k]) * a * (a - 1) / 2;
    end
    return s;
  endfunction

  function automatic longint model_y(input int m);
    return i3_at(DEC*m - 1) - 3*i3_at(DEC*(m-1) - 1)
         + 3*i3_at(DEC*(m-2) - 1) - i3_at(DEC*(m-3) - 1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n_act = 0; m_strobes = 0; m_pend = 1'b0;
      mv = 1'b0; movr = 1'b0; md = '0;
    end else begin
      m_set = 1'b0;
      if (m_pend) begin
        if (!mv || out_ready) begin md = m_pend_y; mv = 1'b1; end
        else begin movr = 1'b1; m_set = 1'b1; end
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      if (!m_set && clr_ovr) movr = 1'b0;
      m_pend = 1'b0;
      if (en && n_act < 8191) begin
        n_act++;
        xh[n_act] = 2*$countones(bs_in) - 3;
        if (n_act % DEC == 0) begin
          m_strobes++;
          if (m_strobes > WARM) begin
            m_pend = 1'b1;
            m_pend_y = OUT_W'(model_y(m_strobes));
          end
        end
      end
    end
  end

  // Every-cycle comparison against the reference
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cyc_valid", longint'(out_valid), longint'(mv));
      check("cyc_data", longint'($signed(out_data)), longint'(md));
      check("cyc_ovr", longint'(ovr), longint'(movr));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int cnt);
    cnt = 0;
    do begin tick(1); cnt++; end while (!out_valid && cnt < bound);
    check("wait_valid_timeout", longint'(out_valid), 1);
  endtask

  int cyc;
  int c;
  int words;

  initial begin
    // 1: constant +3, reset state and first word timing
    tick(2);
    check("reset_valid", longint'(out_valid), 0);
    check("reset_data", longint'(out_data), 0);
    check("reset_ovr", longint'(ovr), 0);
    en = 1'b1; out_ready = 1'b1; bs_in = 3'b111;
    do_reset();
    wait_valid(400, cyc);
    check("first_valid_cycle", cyc, 321);
    check("pos3_first", longint'($signed(out_data)), 786432);
    check("model_pin_pos3", longint'(md), 786432);
    for (int i = 0; i < 3; i++) begin
      wait_valid(100, c);
      check("pos3_period", c, 64);
      check("pos3_word", longint'($signed(out_data)), 786432);
      check("pos3_ovr", longint'(ovr), 0);
    end

    // 2: constant -3
    bs_in = 3'b000;
    do_reset();
    wait_valid(400, cyc);
    check("neg3_first_cycle", cyc, 321);
    check("neg3_word_hex", longint'(out_data), 'h140000);
    check("model_pin_neg3", longint'(md), -786432);
    for (int i = 0; i < 3; i++) begin
      wait_valid(100, c);
      check("neg3_word", longint'($signed(out_data)), -786432);
    end

    // 3: alternating +3/-3 every cycle, 50 words of zero
    bs_in = 3'b111;
    do_reset();
    words = 0;
    for (int i = 0; i < 3460; i++) begin
      tick(1);
      bs_in = (bs_in == 3'b111) ? 3'b000 : 3'b111;
      if (out_valid) begin
        words++;
        check("alt_word", longint'($signed(out_data)), 0);
      end
    end
    check("alt_word_count", words, 50);
    bs_in = 3'b111;

    // 4: constant +1, backpressure, overrun, clear, drain
    bs_in = 3'b011; out_ready = 1'b1;
    do_reset();
    wait_valid(400, cyc);
    check("pos1_first", longint'($signed(out_data)), 262144);
    out_ready = 1'b0;
    tick(63);
    check("ovr_before_strobe", longint'(ovr), 0);
    tick(1);
    check("ovr_after_strobe", longint'(ovr), 1);
    check("held_data", longint'($signed(out_data)), 262144);
    check("held_valid", longint'(out_valid), 1);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    check("ovr_cleared", longint'(ovr), 0);
    out_ready = 1'b1;
    tick(1);
    check("valid_drop_on_accept", longint'(out_valid), 0);
    wait_valid(100, c);
    check("pos1_resume_gap", c, 62);
    check("pos1_resume_word", longint'($signed(out_data)), 262144);

    // 5: en low for 100 cycles mid-stream
    bs_in = 3'b111; out_ready = 1'b1;
    do_reset();
    wait_valid(400, cyc);
    tick(20);
    en = 1'b0;
    tick(100);
    check("en_low_no_valid", longint'(out_valid), 0);
    en = 1'b1;
    wait_valid(100, c);
    check("en_resume_gap", c, 44);
    check("en_resume_word", longint'($signed(out_data)), 786432);
    wait_valid(100, c);
    check("en_resume_period", c, 64);
    check("en_resume_word2", longint'($signed(out_data)), 786432);

    // 6: asynchronous reset mid-period with a pending word and ovr set
    do_reset();
    wait_valid(400, cyc);
    out_ready = 1'b0;
    tick(70);
    check("pre_rst_valid", longint'(out_valid), 1);
    check("pre_rst_ovr", longint'(ovr), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", longint'(out_valid), 0);
    check("async_rst_ovr", longint'(ovr), 0);
    check("async_rst_data", longint'(out_data), 0);
    out_ready = 1'b1;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(400, cyc);
    check("rewarm_first_cycle", cyc, 321);
    check("rewarm_word", longint'($signed(out_data)), 786432);

    tick(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
- Downstream consumer of the three-phase sigma-delta modulator's 3-bit bitstream (sd_out[2:0]).
- Each cycle it maps the three bits to one signed sample, runs it through an ORDER-stage CIC decimator with rate DECIM, and presents full-precision PCM words on a valid/ready interface.
- It includes warm-up suppression, an enable, and sticky overrun detection.
- It is the first multi-bit stage after the modulator and feeds the capture/analysis logic.

Parameters:
- ORDER, 3, number of integrator stages and number of comb stages (1..5).
- DECIM, 64, decimation ratio; power of two, 4..1024.
- LOG2_DECIM, 6, log2(DECIM); must match DECIM.
- OUT_W, 3+ORDER*LOG2_DECIM (21 at defaults), width of the internal accumulators and of out_data.

Ports:
- clk  in  1  system clock, same clock as the modulator.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  when low, the input register, integrators and decimation counter hold.
- bs_in  in  3  modulator bitstream; bit=1 means +1, bit=0 means -1.
- clr_ovr  in  1  synchronous pulse that clears ovr.
- out_data  out  OUT_W  signed two's-complement decimated sample.
- out_valid  out  1  out_data holds an unconsumed sample.
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready.
- ovr  out  1  sticky flag; a sample was dropped.

Behaviour:
- Reset (async assert, sync release):
  - all integrators, combs, comb delay registers, the input register, dec_cnt and warm_cnt go to 0.
  - out_data = 0, out_valid = 0, ovr = 0.
- Input mapping: x = 2*popcount(bs_in) - 3, range {-3,-1,+1,+3}. x is sign-extended to OUT_W and registered into x_r when en is high.
- Integrators: chained, each registered. When en is high: i1 <= i1 + x_r, ik <= ik + i(k-1). All arithmetic wraps modulo 2^OUT_W; overflow is expected and must not saturate.
- Decimation counter:
  - dec_cnt counts 0..DECIM-1 while en is high and wraps to 0.
  - strobe = en && dec_cnt == DECIM-1.
  - en low freezes dec_cnt with no strobe.
- Comb section:
  - Updates only on strobe. c0 = i_ORDER; ck = c(k-1) - d(k-1), with differential delay 1.
  - Delay registers update only on strobe. Comb arithmetic also wraps modulo 2^OUT_W.
  - Result y = c_ORDER is registered on strobe. y is available the cycle after strobe.
- Warm-up:
  - warm_cnt counts strobes up to ORDER+1, then saturates.
  - The first ORDER+1 results after reset are discarded: out_valid is not raised for them, and ovr is unaffected.
- Output register (one-cycle latency after strobe):
  - If not in warm-up and (!out_valid || out_ready): out_data <= y, out_valid <= 1.
  - If not in warm-up and out_valid && !out_ready: out_data is held, the new y is dropped, and ovr <= 1.
  - On out_valid && out_ready with no new sample the same cycle: out_valid <= 0. out_data keeps its last value.
  - Accept and new sample in the same cycle: the new sample is loaded and out_valid stays 1, with no overrun.
- ovr:
  - Set has priority over clr_ovr in the same cycle.
  - Otherwise clr_ovr clears ovr on the next edge.
- en low does not block the output handshake. A pending sample can still be consumed.
- Reset mid-operation: state is lost immediately, and warm-up restarts.
- Steady state for a constant input x: y = x*DECIM^ORDER. At defaults, ±3 gives ±786432 and ±1 gives ±262144.

Test Plan:
- Reset release, en=1, out_ready=1, bs_in=3'b111 constant -> out_valid first rises on cycle 321 after release (after strobe 5), out_data=786432. Each subsequent 64-cycle period delivers one word of 786432; ovr=0.
- bs_in=3'b000 constant, same setup -> out_data=-786432 (0x140000 in 21 bits) every 64 cycles after warm-up.
- bs_in alternating 3'b111/3'b000 each cycle -> post-warm-up out_data=0 every period, with no drift over 50 words.
- bs_in=3'b011 constant, out_ready held 0 after the first word -> out_data stays at 262144 and ovr=1 one cycle after the next strobe. A clr_ovr pulse drops ovr to 0. Raising out_ready lets the next word flow, and out_valid drops on accept when no new sample arrives.
- en=0 for 100 cycles mid-stream with constant 3'b111 -> no strobes and integrators frozen; output cadence resumes with value 786432, and no glitch word is produced.
- rst_n asserted mid-period asynchronously -> out_valid=0, ovr=0 and out_data=0 immediately, and warm-up repeats (5 strobes before the next out_valid).
